// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scan controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        LOCK   = 3'd3,
        HELD   = 3'd4
    } state_t;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int ROW_IDX_W = 2;
    localparam int COL_IDX_W = 2;
    localparam int KEY_W     = 4;

    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'hF;
    localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'hF;

    // Active-low one-hot row drive pattern for a given row index.
    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_col_prio_enc.sv
// Active-low 4-bit column priority encoder: lowest-index low column wins.
module keypad_col_prio_enc
    import keypad_pkg::*;
(
    input  logic [NUM_COLS-1:0]  col_n,
    output logic                 any,
    output logic [COL_IDX_W-1:0] col_idx
);

    // Flag any low column and encode the lowest-index one.
    always_comb begin
        any     = (col_n != COL_IDLE);
        col_idx = 2'd0;
        casez (col_n)
            4'b???0: col_idx = 2'd0;
            4'b??01: col_idx = 2'd1;
            4'b?011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-strobing scan controller for a 4x4 keypad behind a column debouncer.
// Raw columns detect a press, the row is then held so the debouncer sees a
// stable row, and the debounced columns decide the accepted key and release.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Enable,
    input  logic [NUM_COLS-1:0] i_Col_Raw,
    input  logic [NUM_COLS-1:0] i_Col_Db,
    output logic [NUM_ROWS-1:0] o_Row,
    output logic [KEY_W-1:0]    o_Key_Code,
    output logic                o_Key_Valid,
    output logic                o_Key_Held
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_r, state_s;
    logic [ROW_IDX_W-1:0]   idx_r, idx_s;
    logic [SETTLE_W-1:0]    settle_cnt_r, settle_cnt_s;
    logic [TIMEOUT_W-1:0]   timeout_cnt_r, timeout_cnt_s;
    logic [NUM_ROWS-1:0]    row_r, row_s;
    logic [KEY_W-1:0]       key_code_r, key_code_s;
    logic                   key_valid_r, key_valid_s;
    logic                   key_held_r, key_held_s;
    logic [NUM_COLS-1:0]    enc_in_s;
    logic                   enc_any_s;
    logic [COL_IDX_W-1:0]   enc_col_s;

    // Once the row is locked only debounced columns matter; before that, raw ones.
    always_comb begin
        if ((state_r == LOCK) || (state_r == HELD)) begin
            enc_in_s = i_Col_Db;
        end else begin
            enc_in_s = i_Col_Raw;
        end
    end

    keypad_col_prio_enc u_col_enc (
        .col_n   (enc_in_s),
        .any     (enc_any_s),
        .col_idx (enc_col_s)
    );

    // Next-state, row index, counters and key capture.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        settle_cnt_s  = '0;
        timeout_cnt_s = '0;
        key_code_s    = key_code_r;
        key_valid_s   = 1'b0;
        if (!i_Enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = DRIVE;
                end
                DRIVE: begin
                    if (settle_cnt_r >= SETTLE_LAST) begin
                        state_s = SAMPLE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + SETTLE_W'(1);
                    end
                end
                SAMPLE: begin
                    if (enc_any_s) begin
                        state_s = LOCK;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = DRIVE;
                    end
                end
                LOCK: begin
                    if (enc_any_s) begin
                        key_code_s  = {idx_r, enc_col_s};
                        key_valid_s = 1'b1;
                        state_s     = HELD;
                    end else if (timeout_cnt_r >= TIMEOUT_LAST) begin
                        idx_s   = idx_r + 2'd1;
                        state_s = DRIVE;
                    end else begin
                        timeout_cnt_s = timeout_cnt_r + TIMEOUT_W'(1);
                    end
                end
                HELD: begin
                    if (!enc_any_s) begin
                        idx_s   = idx_r + 2'd1;
                        state_s = DRIVE;
                    end else begin
                        state_s = HELD;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        key_held_s = (state_s == HELD);
        if (state_s == IDLE) begin
            row_s = ROW_IDLE;
        end else begin
            row_s = row_drive(idx_s);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            settle_cnt_r  <= '0;
            timeout_cnt_r <= '0;
            row_r         <= ROW_IDLE;
            key_code_r    <= 4'h0;
            key_valid_r   <= 1'b0;
            key_held_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            settle_cnt_r  <= settle_cnt_s;
            timeout_cnt_r <= timeout_cnt_s;
            row_r         <= row_s;
            key_code_r    <= key_code_s;
            key_valid_r   <= key_valid_s;
            key_held_r    <= key_held_s;
        end
    end

    assign o_Row       = row_r;
    assign o_Key_Code  = key_code_r;
    assign o_Key_Valid = key_valid_r;
    assign o_Key_Held  = key_held_r;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad whose four column lines pass through the team's 4-bit column debouncer. It strobes one row at a time and detects a press on the raw columns. It then locks onto that row so the debouncer sees a stable row, waits for the debounced press, and reports a 4-bit key code. It waits for the debounced release before resuming the scan; the block sits between the keypad pins/debouncer and the key-event consumer logic.

Parameters:
SETTLE_CYCLES, 16, clocks a newly driven row is held before raw columns are sampled (wire/pull-up settling).
TIMEOUT_CYCLES, 500000, max clocks in LOCK waiting for a debounced press; must exceed the debouncer's DEBOUNCE_LIMIT.

Ports:
i_Clk  input  1  system clock; single clock domain.
i_Rst_n  input  1  asynchronous, active-low reset.
i_Enable  input  1  1 = scan; 0 = park in IDLE, all rows inactive.
i_Col_Raw  input  4  raw column pins, active-low (pull-ups), already 2-FF synchronised upstream.
i_Col_Db  input  4  debounced columns from the column debouncer, active-low.
o_Row  output  4  row drive, active-low, one-hot-zero (at most one bit low).
o_Key_Code  output  4  {row[1:0], col[1:0]} of the last accepted key.
o_Key_Valid  output  1  one-cycle pulse when o_Key_Code is updated.
o_Key_Held  output  1  high while the accepted key remains debounced-pressed.

Behaviour:
- Reset (async assert, sync release): state IDLE, row index 0, counters 0, o_Row=4'hF, o_Key_Code=0, o_Key_Valid=0, o_Key_Held=0.
- States:
  - IDLE: o_Row=4'hF. If i_Enable, go to DRIVE with row index unchanged.
  - DRIVE: o_Row bit[idx]=0. Count SETTLE_CYCLES clocks, then go to SAMPLE.
  - SAMPLE (1 cycle): if i_Col_Raw!=4'hF, go to LOCK and clear the timeout counter. Otherwise idx=idx+1 (3 wraps to 0) and go to DRIVE.
  - LOCK: row held. If i_Col_Db!=4'hF, capture o_Key_Code={idx, lowest-index low bit of i_Col_Db}, pulse o_Key_Valid and go to HELD. If the counter reaches TIMEOUT_CYCLES first (bounce/glitch), advance idx and go to DRIVE with no valid.
  - HELD: o_Key_Held=1, row held. When i_Col_Db==4'hF, clear o_Key_Held, advance idx and go to DRIVE.
- o_Key_Valid is high exactly in the cycle after LOCK sees the debounced press, coincident with o_Key_Code updating. o_Key_Code otherwise holds its value.
- Latency:
  - Press to valid = scan time to reach the row + SETTLE_CYCLES + 1 + debouncer delay + 1.
  - Full idle scan period = 4*(SETTLE_CYCLES+1) clocks.
- Multiple keys pressed in the locked row: the lowest column index wins. Keys in other rows are ignored until the scan resumes.
- Debounced press on a column differing from the raw-detected one: accept the debounced column.
- i_Enable=0 in any state: next cycle IDLE, o_Row=4'hF, o_Key_Held=0, no valid pulse. A valid due that same cycle is suppressed. idx is kept.
- i_Col_Db already low on entry to LOCK (stale from an earlier row): accepted as a press. The debouncer has settled with this row held by then, because HELD required release before leaving.
- Counter widths: $clog2(max+1). Timeout compare is >=, so no wrap-around.

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, LOCK, HELD}
  - NUM_ROWS=4, NUM_COLS=4
  - COL_IDLE=4'hF
  - key-code width 4
- Sub-module keypad_col_prio_enc: combinational 4-bit active-low priority encoder producing {any, col[1:0]}. Used for the SAMPLE any-test and the LOCK column capture.

Test Plan:
- Bench settings: SETTLE=2, TIMEOUT=40, behavioural debouncer with limit 8 and a keypad model. Reset mid-HELD asserts rows 4'hF and clears held/valid asynchronously. After release, the scan restarts at row 0 in DRIVE.
- No keys pressed, enabled: o_Row cycles 4'hE,D,B,7 each for 3 clocks and wraps. o_Key_Valid never asserts.
- Press row2/col1 clean: scan locks with o_Row=4'hB. One o_Key_Valid pulse with o_Key_Code=4'h9, o_Key_Held=1 until release. After debounced release, o_Row goes to 4'h7.
- Glitch on row1/col3 shorter than the debounce limit: LOCK entered, timeout after 40 clocks, no valid, scan resumes at row 2.
- Row0 cols 1 and 3 pressed together: o_Key_Code=4'h1, exactly one valid pulse.
- i_Enable dropped during LOCK and during HELD: next cycle o_Row=4'hF, o_Key_Held=0, no valid. On re-enable, scanning resumes at the same row.
